// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
package cache_pkg;

   localparam int unsigned INDEX_BITS  = 3;
   localparam int unsigned ADDR_BITS   = 5;
   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned CNT_BITS    = 8;
   localparam int unsigned CACHE_LINES = 2 ** INDEX_BITS;
   localparam int unsigned TAG_BITS    = ADDR_BITS - INDEX_BITS;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StMemRd,
      StMemWr,
      StDone
   } state_t;

   function automatic logic [INDEX_BITS-1:0] line_index(input logic [ADDR_BITS-1:0] addr);
      return addr[INDEX_BITS-1:0];
   endfunction

   function automatic logic [TAG_BITS-1:0] line_tag(input logic [ADDR_BITS-1:0] addr);
      return addr[ADDR_BITS-1:INDEX_BITS];
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: one write port, combinational read, synchronous clear of valid bits.
module cache_line_store #(
   parameter int unsigned INDEX_BITS  = 3,
   parameter int unsigned TAG_BITS    = 2,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned CACHE_LINES = 8
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [INDEX_BITS-1:0] idx,
   input  logic                  valid_we,
   input  logic                  tag_we,
   input  logic                  data_we,
   input  logic                  valid_in,
   input  logic [TAG_BITS-1:0]   tag_in,
   input  logic [DATA_BITS-1:0]  data_in,
   output logic                  valid_out,
   output logic [TAG_BITS-1:0]   tag_out,
   output logic [DATA_BITS-1:0]  data_out
);

   logic [CACHE_LINES-1:0] valid_q;
   logic [TAG_BITS-1:0]    tag_q  [CACHE_LINES];
   logic [DATA_BITS-1:0]   data_q [CACHE_LINES];

   // Only valid bits are cleared; tag/data contents are don't-care once invalid.
   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= '0;
      end else if (valid_we) begin
         valid_q[idx] <= valid_in;
      end
      if (tag_we) begin
         tag_q[idx] <= tag_in;
      end
      if (data_we) begin
         data_q[idx] <= data_in;
      end
   end

   assign valid_out = valid_q[idx];
   assign tag_out   = tag_q[idx];
   assign data_out  = data_q[idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache sequencer: read-allocate, write-through, no-write-allocate,
// with saturating read hit/miss counters.
module cache_controller #(
   parameter int unsigned INDEX_BITS  = 3,
   parameter int unsigned CACHE_LINES = 8,
   parameter int unsigned ADDR_BITS   = 5,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned CNT_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_BITS-1:0] cpu_addr,
   input  logic [DATA_BITS-1:0] cpu_wdata,
   input  logic                 flush,
   output logic                 cpu_done,
   output logic [DATA_BITS-1:0] cpu_rdata,
   output logic                 busy,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   input  logic                 mem_ack,
   input  logic [DATA_BITS-1:0] mem_rdata,
   output logic [CNT_BITS-1:0]  hit_count,
   output logic [CNT_BITS-1:0]  miss_count
);

   import cache_pkg::*;

   state_t                  state;
   logic [ADDR_BITS-1:0]    req_addr;
   logic                    req_we;
   logic [DATA_BITS-1:0]    req_wdata;
   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_BITS-1:0]     req_tag;
   logic                    line_valid;
   logic [TAG_BITS-1:0]     line_tag_q;
   logic [DATA_BITS-1:0]    line_data;
   logic                    hit;
   logic                    fill;
   logic                    write_hit;
   logic                    clear;

   assign idx       = line_index(req_addr);
   assign req_tag   = line_tag(req_addr);
   assign hit       = line_valid && (line_tag_q == req_tag);
   // Array writes are suppressed on a reset edge so an abandoned fill leaves no trace.
   assign fill      = (state == StMemRd) && mem_ack && !reset;
   assign write_hit = (state == StLookup) && req_we && hit && !reset;
   assign clear     = reset || ((state == StIdle) && flush);

   cache_line_store #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS),
      .DATA_BITS  (DATA_BITS),
      .CACHE_LINES(CACHE_LINES)
   ) u_store (
      .clk      (clk),
      .clear    (clear),
      .idx      (idx),
      .valid_we (fill),
      .tag_we   (fill),
      .data_we  (fill || write_hit),
      .valid_in (1'b1),
      .tag_in   (req_tag),
      .data_in  (fill ? mem_rdata : req_wdata),
      .valid_out(line_valid),
      .tag_out  (line_tag_q),
      .data_out (line_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         req_addr   <= '0;
         req_we     <= 1'b0;
         req_wdata  <= '0;
         cpu_done   <= 1'b0;
         cpu_rdata  <= '0;
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               cpu_done <= 1'b0;
               if (!flush && cpu_req) begin
                  req_addr  <= cpu_addr;
                  req_we    <= cpu_we;
                  req_wdata <= cpu_wdata;
                  busy      <= 1'b1;
                  state     <= StLookup;
               end
            end
            StLookup: begin
               if (req_we) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  state     <= StMemWr;
               end else if (hit) begin
                  cpu_rdata <= line_data;
                  cpu_done  <= 1'b1;
                  if (hit_count != {CNT_BITS{1'b1}}) hit_count <= hit_count + 1'b1;
                  state     <= StDone;
               end else begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= req_addr;
                  if (miss_count != {CNT_BITS{1'b1}}) miss_count <= miss_count + 1'b1;
                  state    <= StMemRd;
               end
            end
            StMemRd: begin
               if (mem_ack) begin
                  cpu_rdata <= mem_rdata;
                  cpu_done  <= 1'b1;
                  mem_req   <= 1'b0;
                  state     <= StDone;
               end
            end
            StMemWr: begin
               if (mem_ack) begin
                  cpu_done <= 1'b1;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  state    <= StDone;
               end
            end
            StDone: begin
               cpu_done <= 1'b0;
               busy     <= 1'b0;
               state    <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller against a line/memory array model.
module tb_cache_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req;
   logic       cpu_we;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       flush;
   logic       cpu_done;
   logic [7:0] cpu_rdata;
   logic       busy;
   logic       mem_req;
   logic       mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic [7:0] hit_count;
   logic [7:0] miss_count;

   always #5 clk = ~clk;

   cache_controller #(
      .INDEX_BITS (3),
      .CACHE_LINES(8),
      .ADDR_BITS  (5),
      .DATA_BITS  (8),
      .CNT_BITS   (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .flush     (flush),
      .cpu_done  (cpu_done),
      .cpu_rdata (cpu_rdata),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .hit_count (hit_count),
      .miss_count(miss_count)
   );

   typedef struct {
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       hit;
      int         hits;
      int         misses;
      int         txns;
   } exp_t;

   exp_t       sb[$];

   // Reference model: cache lines plus backing memory.
   bit         m_valid [8];
   logic [1:0] m_tag   [8];
   logic [7:0] m_data  [8];
   logic [7:0] mem     [32];
   int         m_hits;
   int         m_misses;
   int         m_txns;

   int         n_checks;
   int         n_pass;

   logic       mem_auto;
   logic       force_ack;
   logic [7:0] force_rdata;
   int         mem_txns;
   logic [4:0] last_addr;
   logic       last_we;
   logic [7:0] last_wdata;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   // Memory responder: acks after a random delay, or on demand when forced.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = force_rdata;
         end else if (mem_auto && mem_req && ($urandom_range(0, 2) == 0)) begin
            mem_ack    = 1'b1;
            mem_rdata  = mem[mem_addr];
            mem_txns++;
            last_addr  = mem_addr;
            last_we    = mem_we;
            last_wdata = mem_wdata;
         end
      end
   end

   // Monitor: pops one expectation per completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (cpu_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               if (!e.we) chk("rdata", int'(cpu_rdata), int'(e.rdata));
               chk("hit_count", int'(hit_count), e.hits);
               chk("miss_count", int'(miss_count), e.misses);
               chk("mem_txns", mem_txns, e.txns);
               if (e.we || !e.hit) begin
                  chk("mem_addr", int'(last_addr), int'(e.addr));
                  chk("mem_we", int'(last_we), int'(e.we));
                  if (e.we) chk("mem_wdata", int'(last_wdata), int'(e.wdata));
               end
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                         input bit with_flush);
      int   n;
      int   idx;
      logic [1:0] tg;
      exp_t e;
      @(negedge clk);
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      flush     = with_flush;
      if (with_flush) begin
         @(posedge clk);
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         @(negedge clk);
         flush = 1'b0;
         chk("flush_defers_req", int'(busy), 0);
      end
      @(posedge clk);
      idx     = int'(addr[2:0]);
      tg      = addr[4:3];
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = 8'h00;
      e.hit   = m_valid[idx] && (m_tag[idx] == tg);
      if (we) begin
         mem[addr] = wdata;
         if (e.hit) m_data[idx] = wdata;
         m_txns++;
      end else if (e.hit) begin
         e.rdata = m_data[idx];
         if (m_hits < 255) m_hits++;
      end else begin
         e.rdata      = mem[addr];
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_data[idx]  = mem[addr];
         if (m_misses < 255) m_misses++;
         m_txns++;
      end
      e.hits   = m_hits;
      e.misses = m_misses;
      e.txns   = m_txns;
      sb.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            cpu_addr  = 5'($urandom);
            cpu_wdata = 8'($urandom);
            cpu_we    = 1'($urandom);
         end
      end while (!cpu_done && n < 60);
      if (!cpu_done) chk("done_timeout", 0, 1);
      else if (!we && e.hit) chk("hit_latency", n, 2);
      else chk("miss_latency_ge3", int'(n >= 3), 1);
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      n_checks    = 0;
      n_pass      = 0;
      mem_txns    = 0;
      m_txns      = 0;
      mem_auto    = 1'b1;
      force_ack   = 1'b0;
      force_rdata = 8'h00;
      last_addr   = '0;
      last_we     = 1'b0;
      last_wdata  = '0;
      reset       = 1'b1;
      cpu_req     = 1'b0;
      cpu_we      = 1'b0;
      cpu_addr    = '0;
      cpu_wdata   = '0;
      flush       = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         m_tag[i]  = '0;
         m_data[i] = '0;
      end
      model_reset();
      mem[5'b01011] = 8'hA5;
      mem[5'b10011] = 8'h5A;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_done", int'(cpu_done), 0);
      chk("rst_cpu_rdata", int'(cpu_rdata), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_wdata", int'(mem_wdata), 0);
      chk("rst_hit_count", int'(hit_count), 0);
      chk("rst_miss_count", int'(miss_count), 0);
      reset = 1'b0;

      do_req(1'b0, 5'b01011, 8'h00, 1'b0);
      chk("first_read_data", int'(cpu_rdata), 8'hA5);
      do_req(1'b0, 5'b01011, 8'h00, 1'b0);
      chk("repeat_read_hits", int'(hit_count), 1);

      do_req(1'b0, 5'b11011, 8'h00, 1'b0);
      do_req(1'b0, 5'b01011, 8'h00, 1'b0);
      chk("evicted_miss_count", int'(miss_count), 3);

      do_req(1'b1, 5'h0B, 8'h3C, 1'b0);
      do_req(1'b0, 5'h0B, 8'h00, 1'b0);
      chk("write_hit_readback", int'(cpu_rdata), 8'h3C);
      do_req(1'b1, 5'h04, 8'h77, 1'b0);
      do_req(1'b0, 5'h04, 8'h00, 1'b0);

      do_req(1'b0, 5'b01011, 8'h00, 1'b1);

      // Reset while a read fill is outstanding, then a stray ack.
      mem_auto = 1'b0;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 5'b10011;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && n < 20);
      chk("abort_mem_req_seen", int'(mem_req), 1);
      @(negedge clk);
      reset   = 1'b1;
      cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_mem_req_low", int'(mem_req), 0);
      chk("abort_busy_low", int'(busy), 0);
      reset = 1'b0;
      model_reset();
      force_rdata = 8'hEE;
      force_ack   = 1'b1;
      repeat (2) @(negedge clk);
      force_ack = 1'b0;
      mem_auto  = 1'b1;
      do_req(1'b0, 5'b10011, 8'h00, 1'b0);
      chk("abort_no_fill_data", int'(cpu_rdata), 8'h5A);

      for (int i = 0; i < 200; i++) begin
         do_req(1'($urandom_range(0, 2) == 0), 5'($urandom), 8'($urandom),
                $urandom_range(0, 9) == 0);
      end

      do_req(1'b0, 5'h07, 8'h00, 1'b0);
      for (int i = 0; i < 260; i++) do_req(1'b0, 5'h07, 8'h00, 1'b0);
      chk("hit_count_saturates", int'(hit_count), 255);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
